// File: rtl/pill_drop_monitor_pkg.sv
// dispense_pkg: shared dispenser types, monitor FSM states and default 50 MHz timing
package dispense_pkg;
  typedef logic [2:0] pill_cnt_t;
  typedef logic [1:0] mon_state_t;
  localparam mon_state_t S_IDLE   = 2'd0;
  localparam mon_state_t S_WAIT   = 2'd1;
  localparam mon_state_t S_GRACE  = 2'd2;
  localparam mon_state_t S_REPORT = 2'd3;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_TIMEOUT_CYCLES  = 150000000;
  localparam int DEF_GRACE_CYCLES    = 25000000;
  function automatic int max_int(int a, int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/pill_drop_monitor_debouncer.sv
// beam_debouncer: synchronizes an active-low line, accepts stable levels, pulses on accepted falls
module beam_debouncer #(
  parameter int CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic fall
);
  localparam int CW = $clog2(CYCLES + 1);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  // two-flop synchronizer, then accept a new level after CYCLES differing samples in a row
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      level <= 1'b1;
      cnt <= '0;
      fall <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      fall <= 1'b0;
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(CYCLES - 1)) begin
        level <= s2;
        cnt <= '0;
        fall <= level & ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/pill_drop_monitor.sv
// pill_drop_monitor: counts debounced beam drops after a dispense and grades the result
module pill_drop_monitor
  import dispense_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int GRACE_CYCLES    = DEF_GRACE_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] expected,
  input  logic       beam_n,
  output logic       busy,
  output logic       done,
  output logic       ok,
  output logic       short_fault,
  output logic       over_fault,
  output logic [2:0] dropped
);
  localparam int TW = $clog2(max_int(TIMEOUT_CYCLES, GRACE_CYCLES) + 1);
  mon_state_t state;
  pill_cnt_t target, inc;
  logic [TW-1:0] timer;
  logic drop;
  beam_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_beam (
    .clk(CLOCK_50),
    .rst(reset),
    .din(beam_n),
    .fall(drop)
  );
  // status decode and saturating next count
  always_comb begin
    busy = state == S_WAIT || state == S_GRACE;
    done = state == S_REPORT;
    inc = dropped == 3'd7 ? dropped : dropped + 3'd1;
  end
  // check sequencing: wait for the commanded count, then watch for extras during grace
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= S_IDLE;
      target <= '0;
      timer <= '0;
      dropped <= '0;
      ok <= 1'b0;
      short_fault <= 1'b0;
      over_fault <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          target <= expected;
          dropped <= '0;
          ok <= 1'b0;
          short_fault <= 1'b0;
          over_fault <= 1'b0;
          timer <= '0;
          state <= expected != 3'd0 ? S_WAIT : S_GRACE;
        end
        S_WAIT: begin
          timer <= timer + 1'b1;
          if (drop) dropped <= inc;
          if (drop && inc == target) begin
            timer <= '0;
            state <= S_GRACE;
          end else if (timer == TW'(TIMEOUT_CYCLES)) begin
            short_fault <= 1'b1;
            state <= S_REPORT;
          end
        end
        S_GRACE: begin
          timer <= timer + 1'b1;
          if (drop) begin
            dropped <= inc;
            over_fault <= 1'b1;
          end
          if (timer == TW'(GRACE_CYCLES)) begin
            ok <= ~(over_fault | drop);
            state <= S_REPORT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pill_drop_monitor.sv
// tb_pill_drop_monitor: scoreboard bench driven from an event-level reference of drop timing
module tb_pill_drop_monitor;
  localparam int D = 4, T = 100, G = 20, MAXN = 8000;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, beam_n = 1'b1;
  logic [2:0] expected = 3'd0;
  logic busy, done, ok, short_fault, over_fault;
  logic [2:0] dropped;
  int vectors = 0, miscompares = 0;
  int cyc = 0, cyc0 = 0, len = 0, pos = 0;
  bit tl_on = 1'b0;
  bit raw_a[MAXN];
  bit st_a[MAXN];
  bit bexp[MAXN];
  logic [2:0] ex_a[MAXN];
  typedef struct {int tag; bit ok; bit sf; bit of; int drp;} res_t;
  res_t sb[$];

  always #5 clk = ~clk;

  pill_drop_monitor #(.DEBOUNCE_CYCLES(D), .TIMEOUT_CYCLES(T), .GRACE_CYCLES(G)) dut (
    .CLOCK_50(clk), .reset(reset), .start(start), .expected(expected), .beam_n(beam_n),
    .busy(busy), .done(done), .ok(ok), .short_fault(short_fault), .over_fault(over_fault),
    .dropped(dropped)
  );

  task automatic chk(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // monitor: busy every timeline cycle, and each done pulse against the scoreboard head
  always @(posedge clk) begin
    res_t r;
    #1;
    if (tl_on && cyc >= cyc0 && cyc < cyc0 + len) chk("busy", int'(busy), int'(bexp[cyc - cyc0]));
    if (done === 1'b1) begin
      if (sb.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        r = sb.pop_front();
        chk("done_cycle", cyc, r.tag);
        chk("ok", int'(ok), int'(r.ok));
        chk("short_fault", int'(short_fault), int'(r.sf));
        chk("over_fault", int'(over_fault), int'(r.of));
        chk("dropped", int'(dropped), r.drp);
      end
    end
  end

  task automatic step(bit v, bit s, logic [2:0] e, bit r);
    @(negedge clk);
    cyc++;
    beam_n = v;
    start = s;
    expected = e;
    reset = r;
  endtask

  task automatic zero_chk(string n);
    @(posedge clk);
    #1;
    chk({n, "_busy"}, int'(busy), 0);
    chk({n, "_done"}, int'(done), 0);
    chk({n, "_ok"}, int'(ok), 0);
    chk({n, "_short"}, int'(short_fault), 0);
    chk({n, "_over"}, int'(over_fault), 0);
    chk({n, "_dropped"}, int'(dropped), 0);
  endtask

  function automatic void put(bit v, bit s, logic [2:0] e);
    raw_a[pos] = v;
    st_a[pos] = s;
    ex_a[pos] = e;
    pos++;
  endfunction
  function automatic void idle(int n);
    repeat (n) put(1'b1, 1'b0, 3'd0);
  endfunction
  function automatic void blk(int n);
    repeat (n) put(1'b0, 1'b0, 3'd0);
  endfunction
  function automatic void go(int e);
    put(1'b1, 1'b1, 3'(e));
  endfunction

  // reference: drop events from run lengths of the raw beam, then outcome from event windows
  task automatic run_model();
    int drops[$];
    int lvl, run, prev_done;
    lvl = 1;
    run = 0;
    prev_done = -10;
    for (int k = 0; k < pos; k++) begin
      run = (int'(raw_a[k]) != lvl) ? run + 1 : 0;
      if (run == D) begin
        lvl = int'(raw_a[k]);
        run = 0;
        if (lvl == 0) drops.push_back(k + 2);
      end
    end
    for (int k = 0; k < MAXN; k++) bexp[k] = 1'b0;
    for (int s = 0; s < pos; s++) begin
      if (st_a[s] && s >= prev_done + 2) begin
        int e, g, n, c, dt;
        res_t r;
        e = int'(ex_a[s]);
        g = (e == 0) ? s : -1;
        n = 0;
        c = 0;
        r = '{default: 0};
        for (int i = 0; i < drops.size(); i++)
          if (g < 0 && drops[i] >= s && drops[i] <= s + T) begin
            n++;
            if (n == e) g = drops[i] + 1;
          end
        if (g < 0) begin
          r.sf = 1'b1;
          r.drp = n > 7 ? 7 : n;
          dt = s + T + 1;
        end else begin
          for (int i = 0; i < drops.size(); i++)
            if (drops[i] >= g && drops[i] <= g + G) c++;
          dt = g + G + 1;
          r.drp = (e + c) > 7 ? 7 : e + c;
          r.of = c > 0;
          r.ok = c == 0;
        end
        r.tag = cyc0 + dt;
        sb.push_back(r);
        for (int t = s; t < dt && t < MAXN; t++) bexp[t] = 1'b1;
        prev_done = dt;
      end
    end
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 3'd0, 1'b1);
    zero_chk("reset");
    step(1'b1, 1'b1, 3'd3, 1'b0);
    repeat (5) step(1'b1, 1'b0, 3'd0, 1'b0);
    repeat (6) step(1'b0, 1'b0, 3'd0, 1'b0);
    repeat (10) step(1'b1, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_abort_dropped", int'(dropped), 1);
    chk("pre_abort_busy", int'(busy), 1);
    step(1'b1, 1'b0, 3'd0, 1'b1);
    zero_chk("abort");
    repeat (150) step(1'b1, 1'b0, 3'd0, 1'b0);
    chk("abort_idle_busy", int'(busy), 0);

    idle(3);
    go(2); idle(9); blk(10); idle(20); blk(10); idle(60);
    go(3); idle(10); blk(8); idle(120);
    go(1); idle(5); blk(4); idle(4); blk(4); idle(60);
    go(1); idle(5); blk(2); idle(10); blk(6); idle(60);
    go(0); idle(40);
    go(0); idle(5); blk(5); idle(40);
    go(2); idle(5); blk(6); idle(6); go(1); idle(10); blk(6); idle(60);
    go(1); idle(T - 6); blk(6); idle(60);
    go(1); idle(T - 5); blk(6); idle(60);
    go(7); repeat (9) begin blk(4); idle(4); end idle(60);
    repeat (12) begin
      go($urandom_range(0, 7));
      repeat ($urandom_range(0, 9)) begin
        blk($urandom_range(1, 8));
        idle($urandom_range(1, 12));
      end
      idle(160);
    end

    cyc0 = cyc + 1;
    run_model();
    len = pos;
    tl_on = 1'b1;
    for (int k = 0; k < pos; k++) step(raw_a[k], st_a[k], ex_a[k], 1'b0);
    repeat (5) step(1'b1, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #2;
    tl_on = 1'b0;
    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
